// File: rtl/data_memory_ctrl.sv
// Byte-addressed big-endian data memory controller: byte/half/word access with
// sign/zero extension, alignment and range checks, registered response and init fill.
module data_memory_ctrl #(
   parameter int          DEPTH_BYTES = 64,
   parameter logic [31:0] INIT_VALUE  = 32'h0000_0001,
   parameter int          ADDR_W      = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start_init,
   output logic              init_busy,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [1:0]        req_size,
   input  logic              req_unsigned,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   output logic              rsp_valid,
   output logic [31:0]       rsp_rdata,
   output logic              rsp_error
);

   localparam int            AW       = $clog2(DEPTH_BYTES);
   localparam int            WI       = AW - 2;
   localparam logic [WI-1:0] LAST_IDX = WI'(DEPTH_BYTES / 4 - 1);

   typedef enum logic {IDLE, INIT} state_t;

   state_t      state, state_next;
   logic [7:0]  mem [DEPTH_BYTES];
   logic [WI-1:0] init_idx;

   logic          accept_p0, err_p0;
   logic [2:0]    nbytes_p0;
   logic [ADDR_W:0] end_addr_p0;
   logic [AW-1:0] a0_p0, a1_p0, a2_p0, a3_p0;
   logic [31:0]   raw_p0;

   logic          vld_p1, err_p1;
   logic [31:0]   rdata_p1;

   function automatic logic [31:0] extend_load(input logic [1:0] size, input logic uns,
                                               input logic [31:0] raw);
      logic signed [7:0]  b;
      logic signed [15:0] h;
      logic [31:0]        r;
      b = raw[7:0];
      h = raw[15:0];
      case (size)
         2'b00:   r = uns ? {24'd0, raw[7:0]}  : 32'(b);
         2'b01:   r = uns ? {16'd0, raw[15:0]} : 32'(h);
         default: r = raw;
      endcase
      return r;
   endfunction

   // Stage p0: request decode and checks, combinational on the accepting edge
   assign req_ready = (state == IDLE) && !start_init;
   assign accept_p0 = req_valid && req_ready;

   always_comb begin
      nbytes_p0 = 3'd4;
      case (req_size)
         2'b00:   nbytes_p0 = 3'd1;
         2'b01:   nbytes_p0 = 3'd2;
         default: nbytes_p0 = 3'd4;
      endcase
   end

   // Widened by one bit so addresses near the top of the space cannot wrap
   assign end_addr_p0 = {1'b0, req_addr} + (ADDR_W+1)'(nbytes_p0);

   assign err_p0 = (req_size == 2'b11)
                || (req_size == 2'b01 && req_addr[0])
                || (req_size == 2'b10 && req_addr[1:0] != 2'b00)
                || (end_addr_p0 > (ADDR_W+1)'(DEPTH_BYTES));

   assign a0_p0 = req_addr[AW-1:0];
   assign a1_p0 = a0_p0 + AW'(1);
   assign a2_p0 = a0_p0 + AW'(2);
   assign a3_p0 = a0_p0 + AW'(3);

   always_comb begin
      raw_p0 = 32'd0;
      case (req_size)
         2'b00:   raw_p0 = {24'd0, mem[a0_p0]};
         2'b01:   raw_p0 = {16'd0, mem[a0_p0], mem[a1_p0]};
         default: raw_p0 = {mem[a0_p0], mem[a1_p0], mem[a2_p0], mem[a3_p0]};
      endcase
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (start_init) state_next = INIT;
         INIT:    if (init_idx == LAST_IDX) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         init_busy <= 1'b0;
         init_idx  <= '0;
      end else begin
         state     <= state_next;
         init_busy <= (state_next == INIT);
         if (state == INIT)
            init_idx <= (init_idx == LAST_IDX) ? '0 : init_idx + WI'(1);
         else
            init_idx <= '0;
      end
   end

   // Array writes are held off during reset so an aborted fill leaves later words intact
   always_ff @(posedge clk) begin
      if (rst_n) begin
         if (state == INIT) begin
            mem[{init_idx, 2'b00}] <= INIT_VALUE[31:24];
            mem[{init_idx, 2'b01}] <= INIT_VALUE[23:16];
            mem[{init_idx, 2'b10}] <= INIT_VALUE[15:8];
            mem[{init_idx, 2'b11}] <= INIT_VALUE[7:0];
         end else if (accept_p0 && req_write && !err_p0) begin
            case (req_size)
               2'b00: mem[a0_p0] <= req_wdata[7:0];
               2'b01: begin
                  mem[a0_p0] <= req_wdata[15:8];
                  mem[a1_p0] <= req_wdata[7:0];
               end
               default: begin
                  mem[a0_p0] <= req_wdata[31:24];
                  mem[a1_p0] <= req_wdata[23:16];
                  mem[a2_p0] <= req_wdata[15:8];
                  mem[a3_p0] <= req_wdata[7:0];
               end
            endcase
         end
      end
   end

   // Stage p1: registered response
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         vld_p1   <= 1'b0;
         err_p1   <= 1'b0;
         rdata_p1 <= 32'd0;
      end else begin
         vld_p1   <= accept_p0;
         err_p1   <= accept_p0 && err_p0;
         rdata_p1 <= (accept_p0 && !err_p0 && !req_write)
                     ? extend_load(req_size, req_unsigned, raw_p0) : 32'd0;
      end
   end

   assign rsp_valid = vld_p1;
   assign rsp_error = err_p1;
   assign rsp_rdata = rdata_p1;

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Directed bench for data_memory_ctrl: init fill, extended loads, stores, error
// responses, start/request priority, reset abort of fill and back-to-back access.
module tb_data_memory_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start_init;
   logic        init_busy;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_error;

   int nchk  = 0;
   int nfail = 0;

   data_memory_ctrl #(.DEPTH_BYTES(64), .INIT_VALUE(32'h0000_0001), .ADDR_W(32)) dut (
      .clk(clk), .rst_n(rst_n), .start_init(start_init), .init_busy(init_busy),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
      .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
      .rsp_error(rsp_error)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nchk++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic set_req(input logic wr, input logic [1:0] sz, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wd);
      req_valid    = 1'b1;
      req_write    = wr;
      req_size     = sz;
      req_unsigned = uns;
      req_addr     = addr;
      req_wdata    = wd;
   endtask

   // One request, then check the response right after the accepting edge
   task automatic do_req(input string tag, input logic wr, input logic [1:0] sz,
                         input logic uns, input logic [31:0] addr, input logic [31:0] wd,
                         input logic exp_err, input logic [31:0] exp_rdata);
      set_req(wr, sz, uns, addr, wd);
      @(posedge clk); #1;
      req_valid = 1'b0;
      chk({tag, ".valid"}, {31'd0, rsp_valid}, 32'd1);
      chk({tag, ".error"}, {31'd0, rsp_error}, {31'd0, exp_err});
      chk({tag, ".rdata"}, rsp_rdata, exp_rdata);
   endtask

   initial begin
      rst_n = 1'b0; start_init = 1'b0; req_valid = 1'b0; req_write = 1'b0;
      req_size = 2'b10; req_unsigned = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst.init_busy", {31'd0, init_busy}, 32'd0);
      chk("rst.rsp_valid", {31'd0, rsp_valid}, 32'd0);
      chk("rst.rsp_error", {31'd0, rsp_error}, 32'd0);
      chk("rst.rsp_rdata", rsp_rdata, 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("idle.req_ready", {31'd0, req_ready}, 32'd1);

      // Init fill: busy exactly 16 cycles, requests refused throughout
      start_init = 1'b1;
      @(posedge clk); #1;
      start_init = 1'b0;
      set_req(1'b0, 2'b10, 1'b0, 32'd0, 32'd0);
      for (int i = 0; i < 16; i++) begin
         chk("fill.busy", {31'd0, init_busy}, 32'd1);
         chk("fill.ready", {31'd0, req_ready}, 32'd0);
         chk("fill.no_rsp", {31'd0, rsp_valid}, 32'd0);
         @(posedge clk); #1;
      end
      req_valid = 1'b0;
      chk("fill.done", {31'd0, init_busy}, 32'd0);
      @(posedge clk); #1;
      chk("fill.rsp_still_idle", {31'd0, rsp_valid}, 32'd0);
      do_req("ld_w0",  1'b0, 2'b10, 1'b0, 32'd0,  32'd0, 1'b0, 32'h0000_0001);
      do_req("ld_w60", 1'b0, 2'b10, 1'b0, 32'd60, 32'd0, 1'b0, 32'h0000_0001);
      @(posedge clk); #1;
      chk("rsp_deassert", {31'd0, rsp_valid}, 32'd0);

      // Big-endian word store viewed through byte loads
      do_req("st_w8",  1'b1, 2'b10, 1'b0, 32'd8,  32'hA1B2_C3D4, 1'b0, 32'd0);
      do_req("ldbu8",  1'b0, 2'b00, 1'b1, 32'd8,  32'd0, 1'b0, 32'h0000_00A1);
      do_req("ldbu9",  1'b0, 2'b00, 1'b1, 32'd9,  32'd0, 1'b0, 32'h0000_00B2);
      do_req("ldbu10", 1'b0, 2'b00, 1'b1, 32'd10, 32'd0, 1'b0, 32'h0000_00C3);
      do_req("ldbu11", 1'b0, 2'b00, 1'b1, 32'd11, 32'd0, 1'b0, 32'h0000_00D4);
      do_req("ldbs8",  1'b0, 2'b00, 1'b0, 32'd8,  32'd0, 1'b0, 32'hFFFF_FFA1);
      do_req("ldbs9",  1'b0, 2'b00, 1'b0, 32'd9,  32'd0, 1'b0, 32'hFFFF_FFB2);

      // Half store and extended half/word loads
      do_req("st_h12", 1'b1, 2'b01, 1'b0, 32'd12, 32'hFFFF_8001, 1'b0, 32'd0);
      do_req("ldhs12", 1'b0, 2'b01, 1'b0, 32'd12, 32'd0, 1'b0, 32'hFFFF_8001);
      do_req("ldhu12", 1'b0, 2'b01, 1'b1, 32'd12, 32'd0, 1'b0, 32'h0000_8001);
      do_req("ldw12",  1'b0, 2'b10, 1'b0, 32'd12, 32'd0, 1'b0, 32'h8001_0001);
      do_req("ldhs14", 1'b0, 2'b01, 1'b0, 32'd14, 32'd0, 1'b0, 32'h0000_0001);

      // Error responses: misaligned, out of range, illegal size
      do_req("err_ldw6",   1'b0, 2'b10, 1'b0, 32'd6,  32'd0, 1'b1, 32'd0);
      do_req("err_sth3",   1'b1, 2'b01, 1'b0, 32'd3,  32'h0000_FFFF, 1'b1, 32'd0);
      do_req("err_stw62",  1'b1, 2'b10, 1'b0, 32'd62, 32'hFFFF_FFFF, 1'b1, 32'd0);
      do_req("err_size3",  1'b0, 2'b11, 1'b0, 32'd0,  32'd0, 1'b1, 32'd0);
      do_req("err_ldw64",  1'b0, 2'b10, 1'b0, 32'd64, 32'd0, 1'b1, 32'd0);
      do_req("err_ldb64",  1'b0, 2'b00, 1'b1, 32'd64, 32'd0, 1'b1, 32'd0);
      do_req("err_wrap",   1'b0, 2'b10, 1'b0, 32'hFFFF_FFFC, 32'd0, 1'b1, 32'd0);
      do_req("ok_ldb63",   1'b0, 2'b00, 1'b1, 32'd63, 32'd0, 1'b0, 32'h0000_0001);
      do_req("ok_ldh62",   1'b0, 2'b01, 1'b1, 32'd62, 32'd0, 1'b0, 32'h0000_0001);
      do_req("unchg_w0",   1'b0, 2'b10, 1'b0, 32'd0,  32'd0, 1'b0, 32'h0000_0001);
      do_req("unchg_w60",  1'b0, 2'b10, 1'b0, 32'd60, 32'd0, 1'b0, 32'h0000_0001);

      // Back-to-back store then load of the same word
      set_req(1'b1, 2'b10, 1'b0, 32'd20, 32'hDEAD_BEEF);
      @(posedge clk); #1;
      chk("b2b.st_valid", {31'd0, rsp_valid}, 32'd1);
      chk("b2b.st_rdata", rsp_rdata, 32'd0);
      set_req(1'b0, 2'b10, 1'b0, 32'd20, 32'd0);
      @(posedge clk); #1;
      req_valid = 1'b0;
      chk("b2b.ld_valid", {31'd0, rsp_valid}, 32'd1);
      chk("b2b.ld_rdata", rsp_rdata, 32'hDEAD_BEEF);
      @(posedge clk); #1;
      chk("b2b.deassert", {31'd0, rsp_valid}, 32'd0);

      // start_init wins over a same-cycle request; reset aborts the fill at word 5
      start_init = 1'b1;
      set_req(1'b0, 2'b10, 1'b0, 32'd0, 32'd0);
      #1;
      chk("prio.ready", {31'd0, req_ready}, 32'd0);
      @(posedge clk); #1;
      start_init = 1'b0;
      req_valid  = 1'b0;
      chk("prio.no_rsp", {31'd0, rsp_valid}, 32'd0);
      chk("prio.busy", {31'd0, init_busy}, 32'd1);
      repeat (5) @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      chk("abort.busy", {31'd0, init_busy}, 32'd0);
      chk("abort.valid", {31'd0, rsp_valid}, 32'd0);
      chk("abort.error", {31'd0, rsp_error}, 32'd0);
      chk("abort.rdata", rsp_rdata, 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      do_req("abort.w0", 1'b0, 2'b10, 1'b0, 32'd0,  32'd0, 1'b0, 32'h0000_0001);
      do_req("abort.w2", 1'b0, 2'b10, 1'b0, 32'd8,  32'd0, 1'b0, 32'h0000_0001);
      do_req("abort.w3", 1'b0, 2'b10, 1'b0, 32'd12, 32'd0, 1'b0, 32'h0000_0001);
      do_req("abort.w4", 1'b0, 2'b10, 1'b0, 32'd16, 32'd0, 1'b0, 32'h0000_0001);
      do_req("abort.w5", 1'b0, 2'b10, 1'b0, 32'd20, 32'd0, 1'b0, 32'hDEAD_BEEF);

      $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
      $finish;
   end

endmodule
